// File: rtl/counter_mode_sequencer.sv
// -----------------------------------------------------------------------------
// counter_mode_sequencer
//
// Drives the 2-bit mode input of the 4-bit counter from a small table of
// (mode, duration) segments. Each segment holds its mode for exactly len
// cycles. Segments follow back to back with no gap cycles. The program ends at
// the first zero-length entry or after the last table slot. If loop was
// sampled high at start, the program wraps to segment 0 instead of ending.
//
// Parameters
//   DEPTH     number of table entries (power of two, >= 2)
//   LEN_W     width of the segment length field
//   IDLE_MODE mode presented whenever no program is running
//
// Ports
//   clk      clock, rising-edge
//   rst      synchronous active-high reset (clears the table lengths)
//   wr_en    write one table entry (ignored while busy)
//   wr_addr  entry index to write
//   wr_mode  mode stored in the entry
//   wr_len   cycle count stored in the entry; 0 marks end of program
//   start    begin execution (sampled only when idle)
//   loop     sampled with start; repeat the program until abort
//   abort    stop the running program immediately, no done pulse
//   mode     registered mode toward the counter
//   seg_idx  registered index of the active segment
//   busy     registered, high while a program runs
//   done     registered one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module counter_mode_sequencer #(
    parameter int         DEPTH     = 8,
    parameter int         LEN_W     = 6,
    parameter logic [1:0] IDLE_MODE = 2'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [1:0]                 wr_mode,
    input  logic [LEN_W-1:0]           wr_len,
    input  logic                       start,
    input  logic                       loop,
    input  logic                       abort,
    output logic [1:0]                 mode,
    output logic [$clog2(DEPTH)-1:0]   seg_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // Segment table
    logic [1:0]       mode_tab [DEPTH];
    logic [LEN_W-1:0] len_tab  [DEPTH];

    // Sequencer state
    state_t           state, state_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic             loop_q, loop_nx;
    logic [1:0]       mode_nx;
    logic [AW-1:0]    seg_idx_nx;
    logic             busy_nx;
    logic             done_nx;

    // Lookahead to the following segment
    logic [AW-1:0]    next_idx;
    logic             last_slot;
    logic             table_wr;

    assign next_idx  = seg_idx + AW'(1);
    assign last_slot = (seg_idx == AW'(DEPTH - 1));

    // busy is the registered view of RUN, so a write in the same cycle as a
    // start still lands, while start reads the pre-write entry 0.
    assign table_wr  = wr_en && !busy && !rst;

    // Only the lengths need clearing: a zero length makes every mode value
    // unreachable, so the mode array can stay unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                len_tab[i] <= '0;
            end
        end else if (table_wr) begin
            len_tab[wr_addr] <= wr_len;
        end
    end

    always_ff @(posedge clk) begin
        if (table_wr) begin
            mode_tab[wr_addr] <= wr_mode;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            loop_q    <= 1'b0;
            mode      <= IDLE_MODE;
            seg_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            loop_q    <= loop_nx;
            mode      <= mode_nx;
            seg_idx   <= seg_idx_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        loop_nx      = loop_q;
        mode_nx      = mode;
        seg_idx_nx   = seg_idx;
        busy_nx      = busy;
        done_nx      = 1'b0;

        unique case (state)
            S_IDLE: begin
                mode_nx    = IDLE_MODE;
                seg_idx_nx = '0;
                busy_nx    = 1'b0;
                if (start) begin
                    if (len_tab[0] != '0) begin
                        state_nx     = S_RUN;
                        mode_nx      = mode_tab[0];
                        remaining_nx = len_tab[0] - LEN_W'(1);
                        loop_nx      = loop;
                        busy_nx      = 1'b1;
                    end else begin
                        // Empty program completes at once.
                        done_nx = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_nx   = S_IDLE;
                    mode_nx    = IDLE_MODE;
                    seg_idx_nx = '0;
                    busy_nx    = 1'b0;
                end else if (remaining != '0) begin
                    remaining_nx = remaining - LEN_W'(1);
                end else if (!last_slot && (len_tab[next_idx] != '0)) begin
                    mode_nx      = mode_tab[next_idx];
                    seg_idx_nx   = next_idx;
                    remaining_nx = len_tab[next_idx] - LEN_W'(1);
                end else if (loop_q) begin
                    // A running program always has a nonzero entry 0, since
                    // the table is frozen while busy.
                    mode_nx      = mode_tab[0];
                    seg_idx_nx   = '0;
                    remaining_nx = len_tab[0] - LEN_W'(1);
                end else begin
                    state_nx   = S_IDLE;
                    mode_nx    = IDLE_MODE;
                    seg_idx_nx = '0;
                    busy_nx    = 1'b0;
                    done_nx    = 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_mode_sequencer
//
// Self-checking bench for counter_mode_sequencer. Expected per-cycle outputs
// {mode, seg_idx, busy, done} are derived from the segment lists and queued
// when a program is launched. They are then popped and compared one per clock.
// -----------------------------------------------------------------------------
module tb_counter_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [1:0] wr_mode;
    logic [5:0] wr_len;
    logic       start;
    logic       loop;
    logic       abort;
    logic [1:0] mode;
    logic [2:0] seg_idx;
    logic       busy;
    logic       done;

    counter_mode_sequencer #(
        .DEPTH    (8),
        .LEN_W    (6),
        .IDLE_MODE(2'd1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_mode(wr_mode),
        .wr_len (wr_len),
        .start  (start),
        .loop   (loop),
        .abort  (abort),
        .mode   (mode),
        .seg_idx(seg_idx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0] m;
        logic [2:0] s;
        logic       b;
        logic       d;
    } exp_t;

    typedef struct {
        logic [7:0][1:0] m;
        logic [7:0][5:0] l;
        int              exp_busy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[3];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got mode=%0d seg=%0d busy=%0b done=%0b, expected mode=%0d seg=%0d busy=%0b done=%0b",
                     nm, got.m, got.s, got.b, got.d, exp.m, exp.s, exp.b, exp.d);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [2:0] s, input logic b, input logic d);
        exp_t e;
        e.m = m; e.s = s; e.b = b; e.d = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [5:0] l);
        wr_en = 1'b1; wr_addr = a; wr_mode = m; wr_len = l;
        tick();
        wr_en = 1'b0;
    endtask

    // Non-looping program: each segment for len cycles, then done, then idle.
    task automatic push_prog(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            if (v.l[i] == 6'd0) break;
            for (int k = 0; k < int'(v.l[i]); k++) push(v.m[i], 3'(i), 1'b1, 1'b0);
        end
        push(2'd1, 3'd0, 1'b0, 1'b1);
        push(2'd1, 3'd0, 1'b0, 1'b0);
    endtask

    // Caller raises start (and loop) beforehand. Hook indices (-1 = unused)
    // act after the output of that queue index has been compared.
    task automatic drain(input string nm, input int hold_until, input int disturb_at,
                         input int abort_at, input int rst_at);
        exp_t e;
        int   i;
        tick();
        if (hold_until < 0) start = 1'b0;
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(nm, {mode, seg_idx, busy, done}, e);
            if (busy) busy_cnt++;
            if (i == hold_until) start = 1'b0;
            if (i == disturb_at) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_mode = 2'd0; wr_len = 6'd5;
                start = 1'b1;
            end
            if (i == abort_at) abort = 1'b1;
            if (i == rst_at) rst = 1'b1;
            tick();
            if (i == disturb_at) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            abort = 1'b0;
            rst   = 1'b0;
            i++;
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_len = '0;
        start = 1'b0; loop = 1'b0; abort = 1'b0;

        // Vector table: entry 7 first in each packed literal.
        vecs[0].m = {2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2};
        vecs[0].l = {6'd0, 6'd10, 6'd12, 6'd6, 6'd6, 6'd7, 6'd12, 6'd17};
        vecs[0].exp_busy = 70;
        vecs[1].m = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        vecs[1].l = {6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
        vecs[1].exp_busy = 8;
        vecs[2].m = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        vecs[2].l = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd63};
        vecs[2].exp_busy = 64;

        tick();
        do_reset();
        chk("reset_state", {mode, seg_idx, busy, done}, {2'd1, 3'd0, 1'b0, 1'b0});

        // Empty table right after reset.
        start = 1'b1;
        push(2'd1, 3'd0, 1'b0, 1'b1);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        drain("empty_prog", -1, -1, -1, -1);

        // Table-driven programs.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int e = 0; e < 8; e++) wr(3'(e), vecs[v].m[e], vecs[v].l[e]);
            push_prog(vecs[v]);
            busy_cnt = 0;
            loop  = 1'b0;
            start = 1'b1;
            drain($sformatf("vec%0d", v), -1, -1, -1, -1);
            chk_int($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
        end

        // Looping 3,2,3,2,... then abort after five busy cycles.
        do_reset();
        wr(3'd0, 2'd3, 6'd1);
        wr(3'd1, 2'd2, 6'd1);
        push(2'd3, 3'd0, 1'b1, 1'b0);
        push(2'd2, 3'd1, 1'b1, 1'b0);
        push(2'd3, 3'd0, 1'b1, 1'b0);
        push(2'd2, 3'd1, 1'b1, 1'b0);
        push(2'd3, 3'd0, 1'b1, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        loop  = 1'b1;
        start = 1'b1;
        drain("loop_abort", -1, -1, 4, -1);
        loop = 1'b0;

        // Write to entry 0 and start while busy: both ignored, rerun identical.
        do_reset();
        wr(3'd0, 2'd2, 6'd3);
        wr(3'd1, 2'd1, 6'd2);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) push(2'd2, 3'd0, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) push(2'd1, 3'd1, 1'b1, 1'b0);
            push(2'd1, 3'd0, 1'b0, 1'b1);
            push(2'd1, 3'd0, 1'b0, 1'b0);
            start = 1'b1;
            drain($sformatf("busy_ignore_run%0d", r), -1, (r == 0) ? 1 : -1, -1, -1);
        end

        // start held high re-triggers one cycle after done.
        do_reset();
        wr(3'd0, 2'd2, 6'd2);
        push(2'd2, 3'd0, 1'b1, 1'b0);
        push(2'd2, 3'd0, 1'b1, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b1);
        push(2'd2, 3'd0, 1'b1, 1'b0);
        push(2'd2, 3'd0, 1'b1, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b1);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        start = 1'b1;
        drain("start_held", 3, -1, -1, -1);

        // Reset in the middle of segment 2, then the table must be empty.
        do_reset();
        wr(3'd0, 2'd2, 6'd3);
        wr(3'd1, 2'd1, 6'd3);
        wr(3'd2, 2'd3, 6'd4);
        for (int k = 0; k < 3; k++) push(2'd2, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) push(2'd1, 3'd1, 1'b1, 1'b0);
        push(2'd3, 3'd2, 1'b1, 1'b0);
        push(2'd3, 3'd2, 1'b1, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        start = 1'b1;
        drain("reset_mid_run", -1, -1, -1, 7);
        push(2'd1, 3'd0, 1'b0, 1'b1);
        push(2'd1, 3'd0, 1'b0, 1'b0);
        start = 1'b1;
        drain("after_reset_empty", -1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
